// File: rtl/cp0_excpt_src_if.sv
// Pipeline <-> CP0 exception-source bundle: MEM-stage instruction info, MTC0/MFC0 access,
// exception controller handshake and the excptype/epc results.
interface cp0_excpt_src_if #(
  parameter int HW_INTS = 6
);
  logic [HW_INTS-1:0] hw_int_i;
  logic               syscall_i;
  logic               eret_i;
  logic [31:0]        inst_pc_i;
  logic               in_ds_i;
  logic               inst_valid_i;
  logic               excpt_i;
  logic               cp0_we_i;
  logic [4:0]         cp0_waddr_i;
  logic [31:0]        cp0_wdata_i;
  logic [4:0]         cp0_raddr_i;
  logic [31:0]        cp0_rdata_o;
  logic [31:0]        excptype_o;
  logic [31:0]        epc_o;
  logic               timer_int_o;

  modport master (
    output hw_int_i, syscall_i, eret_i, inst_pc_i, in_ds_i, inst_valid_i, excpt_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
    input  cp0_rdata_o, excptype_o, epc_o, timer_int_o
  );

  modport slave (
    input  hw_int_i, syscall_i, eret_i, inst_pc_i, in_ds_i, inst_valid_i, excpt_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
    output cp0_rdata_o, excptype_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_excpt_src.sv
// CP0 exception source: Count/Compare/Status/Cause/EPC state, exception prioritisation and the
// state update applied when the exception controller accepts an exception.
module cp0_excpt_src #(
  parameter int          HW_INTS    = 6,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  cp0_excpt_src_if.slave bus
);

  localparam logic [4:0]  A_COUNT   = 5'd9;
  localparam logic [4:0]  A_COMPARE = 5'd11;
  localparam logic [4:0]  A_STATUS  = 5'd12;
  localparam logic [4:0]  A_CAUSE   = 5'd13;
  localparam logic [4:0]  A_EPC     = 5'd14;

  localparam logic [31:0] EXC_NONE  = 32'h0;
  localparam logic [31:0] EXC_INT   = 32'h1;
  localparam logic [31:0] EXC_SYS   = 32'h8;
  localparam logic [31:0] EXC_ERET  = 32'he;

  logic [31:0]        count_q;
  logic [31:0]        compare_q;
  logic [31:0]        epc_q;
  logic [7:0]         im_q;
  logic               exl_q;
  logic               ie_q;
  logic               bd_q;
  logic [1:0]         ip_sw_q;
  logic [4:0]         exccode_q;
  logic [HW_INTS-1:0] hw_q;
  logic               timer_q;

  logic [7:0]  ip;
  logic        int_pend;
  logic [31:0] excptype;
  logic        accept;
  logic        acc_exc;
  logic        acc_eret;
  logic        wr_en;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        fwd;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] rdata;

  // Top hardware line shares IP[7] with the timer; the rest map straight onto IP[6:2].
  assign ip       = {timer_q | hw_q[HW_INTS-1], hw_q[HW_INTS-2:0], ip_sw_q};
  assign int_pend = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    excptype = EXC_NONE;
    if (bus.inst_valid_i) begin
      if (int_pend)           excptype = EXC_INT;
      else if (bus.syscall_i) excptype = EXC_SYS;
      else if (bus.eret_i)    excptype = EXC_ERET;
    end
  end

  assign accept   = bus.excpt_i & (excptype != EXC_NONE);
  assign acc_exc  = accept & (excptype != EXC_ERET);
  assign acc_eret = accept & (excptype == EXC_ERET);

  // The accepted instruction is flushed, so an MTC0 it carries must not commit.
  assign wr_en      = bus.cp0_we_i & ~accept;
  assign wr_count   = wr_en & (bus.cp0_waddr_i == A_COUNT);
  assign wr_compare = wr_en & (bus.cp0_waddr_i == A_COMPARE);
  assign wr_status  = wr_en & (bus.cp0_waddr_i == A_STATUS);
  assign wr_cause   = wr_en & (bus.cp0_waddr_i == A_CAUSE);
  assign wr_epc     = wr_en & (bus.cp0_waddr_i == A_EPC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      epc_q     <= 32'h0;
      im_q      <= STATUS_RST[15:8];
      exl_q     <= STATUS_RST[1];
      ie_q      <= STATUS_RST[0];
      bd_q      <= 1'b0;
      ip_sw_q   <= 2'b00;
      exccode_q <= 5'd0;
      hw_q      <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q <= wr_count ? bus.cp0_wdata_i : count_q + 32'd1;
      hw_q    <= bus.hw_int_i;

      if (wr_compare) compare_q <= bus.cp0_wdata_i;

      // Writing Compare acknowledges the timer, even if it matches again this cycle.
      if (wr_compare)
        timer_q <= 1'b0;
      else if ((count_q == compare_q) && (compare_q != 32'h0))
        timer_q <= 1'b1;

      if (wr_status) begin
        im_q  <= bus.cp0_wdata_i[15:8];
        exl_q <= bus.cp0_wdata_i[1];
        ie_q  <= bus.cp0_wdata_i[0];
      end

      if (wr_cause) ip_sw_q <= bus.cp0_wdata_i[9:8];
      if (wr_epc)   epc_q   <= bus.cp0_wdata_i;

      if (acc_exc) begin
        epc_q     <= bus.in_ds_i ? bus.inst_pc_i - 32'd4 : bus.inst_pc_i;
        bd_q      <= bus.in_ds_i;
        exccode_q <= (excptype == EXC_INT) ? 5'd0 : 5'd8;
        exl_q     <= 1'b1;
      end else if (acc_eret) begin
        exl_q <= 1'b0;
      end
    end
  end

  assign status_rd = {16'h0, im_q, 6'h0, exl_q, ie_q};
  assign cause_rd  = {bd_q, 15'h0, ip, 1'b0, exccode_q, 2'b00};
  assign fwd       = bus.cp0_we_i & (bus.cp0_waddr_i == bus.cp0_raddr_i);

  // Forwarded views only expose the fields an MTC0 can actually change.
  always_comb begin
    rdata = 32'h0;
    case (bus.cp0_raddr_i)
      A_COUNT:   rdata = fwd ? bus.cp0_wdata_i : count_q;
      A_COMPARE: rdata = fwd ? bus.cp0_wdata_i : compare_q;
      A_STATUS:  rdata = fwd ? {16'h0, bus.cp0_wdata_i[15:8], 6'h0, bus.cp0_wdata_i[1:0]}
                             : status_rd;
      A_CAUSE:   rdata = fwd ? {bd_q, 15'h0, ip[7:2], bus.cp0_wdata_i[9:8], 1'b0, exccode_q, 2'b00}
                             : cause_rd;
      A_EPC:     rdata = fwd ? bus.cp0_wdata_i : epc_q;
      default:   rdata = 32'h0;
    endcase
  end

  assign bus.cp0_rdata_o = rdata;
  assign bus.excptype_o  = excptype;
  assign bus.epc_o       = (bus.cp0_we_i && (bus.cp0_waddr_i == A_EPC)) ? bus.cp0_wdata_i : epc_q;
  assign bus.timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_excpt_src.sv
// Bench for cp0_excpt_src: table of one-cycle vectors plus hand sequences for timer, wrap,
// forwarding and reset; expectations go through a queue and are checked before the next edge.
module tb_cp0_excpt_src;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_excpt_src_if #(.HW_INTS(6)) bus ();

  cp0_excpt_src #(.HW_INTS(6), .STATUS_RST(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ctl bits: {inst_valid, excpt, syscall, eret, in_ds}
  localparam logic [4:0] V = 5'b10000;
  localparam logic [4:0] X = 5'b01000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] E = 5'b00010;
  localparam logic [4:0] D = 5'b00001;

  // chk bits: {rdata, excptype, epc, timer}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [5:0]  hw;
    logic [3:0]  chk;
    logic [31:0] e_rd;
    logic [31:0] e_type;
    logic [31:0] e_epc;
    logic        e_tmr;
  } vec_t;

  typedef struct {
    string       nm;
    logic [3:0]  chk;
    logic [31:0] rd;
    logic [31:0] typ;
    logic [31:0] epc;
    logic        tmr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] pc, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra,
                              input logic [5:0] hw, input logic [31:0] e_rd,
                              input logic [31:0] e_type, input logic [31:0] e_epc);
    vec_t v;
    v.ctl = ctl; v.pc = pc; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.hw = hw;
    v.chk = 4'b1111; v.e_rd = e_rd; v.e_type = e_type; v.e_epc = e_epc; v.e_tmr = 1'b0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.inst_valid_i = v.ctl[4];
    bus.excpt_i      = v.ctl[3];
    bus.syscall_i    = v.ctl[2];
    bus.eret_i       = v.ctl[1];
    bus.in_ds_i      = v.ctl[0];
    bus.inst_pc_i    = v.pc;
    bus.cp0_we_i     = v.we;
    bus.cp0_waddr_i  = v.wa;
    bus.cp0_wdata_i  = v.wd;
    bus.cp0_raddr_i  = v.ra;
    bus.hw_int_i     = v.hw;
  endtask

  task automatic cyc(input vec_t v, input string nm);
    exp_t e;
    drive(v);
    e.nm = nm; e.chk = v.chk; e.rd = v.e_rd; e.typ = v.e_type; e.epc = v.e_epc; e.tmr = v.e_tmr;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk[3]) check({e.nm, ".rdata"},    bus.cp0_rdata_o, e.rd);
    if (e.chk[2]) check({e.nm, ".excptype"}, bus.excptype_o,  e.typ);
    if (e.chk[1]) check({e.nm, ".epc"},      bus.epc_o,       e.epc);
    if (e.chk[0]) check({e.nm, ".timer"},    {31'h0, bus.timer_int_o}, {31'h0, e.tmr});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t t;

    //                ctl        pc       we wa  wd             ra  hw  rdata          type   epc
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          9,  0, 32'h0,         32'h0, 32'h0));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          12, 0, 32'h0,         32'h0, 32'h0));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          13, 0, 32'h0,         32'h0, 32'h0));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          14, 0, 32'h0,         32'h0, 32'h0));
    tbl.push_back(mk(V|S|X,     32'h100, 0, 0,  32'h0,          14, 0, 32'h0,         32'h8, 32'h0));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          14, 0, 32'h100,       32'h0, 32'h100));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          12, 0, 32'h2,         32'h0, 32'h100));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          13, 0, 32'h20,        32'h0, 32'h100));
    tbl.push_back(mk(V|S|X|D,   32'h100, 0, 0,  32'h0,          14, 0, 32'h100,       32'h8, 32'h100));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          14, 0, 32'hFC,        32'h0, 32'hFC));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          13, 0, 32'h8000_0020, 32'h0, 32'hFC));
    tbl.push_back(mk(V,         32'h0,   1, 14, 32'h200,        14, 0, 32'h200,       32'h0, 32'h200));
    tbl.push_back(mk(V|E|X,     32'h0,   0, 0,  32'h0,          12, 0, 32'h2,         32'he, 32'h200));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          12, 0, 32'h0,         32'h0, 32'h200));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          14, 0, 32'h200,       32'h0, 32'h200));
    tbl.push_back(mk(V,         32'h0,   1, 12, 32'h401,        12, 1, 32'h401,       32'h0, 32'h200));
    tbl.push_back(mk(V|S,       32'h0,   0, 0,  32'h0,          13, 1, 32'h8000_0420, 32'h1, 32'h200));
    tbl.push_back(mk(S,         32'h0,   0, 0,  32'h0,          13, 1, 32'h8000_0420, 32'h0, 32'h200));
    tbl.push_back(mk(V|S|X,     32'h400, 0, 0,  32'h0,          14, 1, 32'h200,       32'h1, 32'h200));
    tbl.push_back(mk(V|S,       32'h0,   0, 0,  32'h0,          12, 1, 32'h403,       32'h8, 32'h400));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          13, 1, 32'h400,       32'h0, 32'h400));
    tbl.push_back(mk(V|S|X,     32'h500, 1, 12, 32'h0,          11, 0, 32'h0,         32'h8, 32'h400));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          12, 0, 32'h403,       32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   1, 12, 32'h0,          13, 0, 32'h20,        32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   1, 13, 32'hFFFF_FFFF,  13, 0, 32'h320,       32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          13, 0, 32'h320,       32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   1, 12, 32'h101,        12, 0, 32'h101,       32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          12, 0, 32'h101,       32'h1, 32'h500));
    tbl.push_back(mk(V,         32'h0,   1, 13, 32'h0,          13, 0, 32'h20,        32'h1, 32'h500));
    tbl.push_back(mk(V,         32'h0,   1, 5,  32'hDEAD_BEEF,  5,  0, 32'h0,         32'h0, 32'h500));
    tbl.push_back(mk(V,         32'h0,   0, 0,  32'h0,          9,  0, 32'd30,        32'h0, 32'h500));

    drive(mk(5'b0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[i]) cyc(tbl[i], $sformatf("tbl[%0d]", i));

    // Timer: Status IM7|IE, Compare=10, then Count restarted from 0.
    cyc(mk(V, 32'h0, 1, 12, 32'h8001, 12, 0, 32'h8001, 32'h0, 32'h500), "tmr_status");
    cyc(mk(V, 32'h0, 1, 11, 32'd10,   11, 0, 32'd10,   32'h0, 32'h500), "tmr_cmp");
    cyc(mk(V, 32'h0, 1, 9,  32'd0,    9,  0, 32'd0,    32'h0, 32'h500), "tmr_cnt");
    for (int k = 0; k <= 10; k++)
      cyc(mk(V, 32'h0, 0, 0, 32'h0, 9, 0, k, 32'h0, 32'h500), $sformatf("tmr_run[%0d]", k));
    t = mk(V, 32'h0, 0, 0, 32'h0, 9, 0, 32'd11, 32'h0, 32'h500);
    t.chk = 4'b1001; t.e_tmr = 1'b1;
    cyc(t, "tmr_set");
    t = mk(V, 32'h0, 1, 11, 32'h0, 9, 0, 32'd12, 32'h1, 32'h500);
    t.e_tmr = 1'b1;
    cyc(t, "tmr_int");
    cyc(mk(V, 32'h0, 0, 0, 32'h0, 9, 0, 32'd13, 32'h0, 32'h500), "tmr_clr");

    // Compare rewritten on the very cycle Count matches it: the clear must win.
    cyc(mk(V, 32'h0, 1, 11, 32'd100, 11, 0, 32'd100, 32'h0, 32'h500), "cw_cmp");
    cyc(mk(V, 32'h0, 1, 9,  32'd100, 9,  0, 32'd100, 32'h0, 32'h500), "cw_cnt");
    cyc(mk(V, 32'h0, 1, 11, 32'd100, 9,  0, 32'd100, 32'h0, 32'h500), "cw_match");
    cyc(mk(V, 32'h0, 0, 0,  32'h0,   9,  0, 32'd101, 32'h0, 32'h500), "cw_after");

    cyc(mk(V, 32'h0, 1, 9, 32'hFFFF_FFFF, 11, 0, 32'd100,       32'h0, 32'h500), "wrap_set");
    cyc(mk(V, 32'h0, 0, 0, 32'h0,         9,  0, 32'hFFFF_FFFF, 32'h0, 32'h500), "wrap_max");
    cyc(mk(V, 32'h0, 0, 0, 32'h0,         9,  0, 32'h0,         32'h0, 32'h500), "wrap_zero");

    cyc(mk(V|E, 32'h0, 1, 14, 32'h300, 12, 0, 32'h8001, 32'he, 32'h300), "fwd_eret");
    cyc(mk(V,   32'h0, 0, 0,  32'h0,   14, 0, 32'h300,  32'h0, 32'h300), "fwd_epc");

    // Reset asserted on the same edge an exception is accepted.
    drive(mk(V|S|X|D, 32'h700, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(mk(V, 32'h0, 0, 0, 32'h0, 9,  0, 32'h0, 32'h0, 32'h0), "rst_count");
    cyc(mk(V, 32'h0, 0, 0, 32'h0, 12, 0, 32'h0, 32'h0, 32'h0), "rst_status");
    cyc(mk(V, 32'h0, 0, 0, 32'h0, 13, 0, 32'h0, 32'h0, 32'h0), "rst_cause");
    cyc(mk(V, 32'h0, 0, 0, 32'h0, 11, 0, 32'h0, 32'h0, 32'h0), "rst_compare");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
